// File: rtl/regfile_scoreboard_pkg.sv
// Shared register-index types for the RV32I register file and its scoreboard.
package regfile_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_index_t;

    localparam reg_index_t REG_ZERO = 5'd0;

    // x0 is hardwired, so it never participates in hazard tracking.
    function automatic logic is_tracked(input reg_index_t idx);
        return (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/pending_counter_m.sv
// Per-register pending-write counter: saturating up/down count with clear.
module pending_counter_m #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next count; inc and dec together cancel, both ends saturate.
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = CNT_ZERO;
        end else if (inc && !dec) begin
            if (count_r != CNT_MAX) begin
                count_nxt_s = count_r + CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else if (dec && !inc) begin
            if (count_r != CNT_ZERO) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;
    assign full  = (count_r == CNT_MAX);

    regfile_scoreboard_checker #(.W(CNT_W)) u_chk (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (inc),
        .dec   (dec),
        .count (count_r)
    );

endmodule

// File: rtl/regfile_scoreboard_checker.sv
// Simulation-only guard: flags a decrement of an empty counter, which means
// writeback retired something that was never issued.
module regfile_scoreboard_checker #(
    parameter int W = 2
) (
    input logic         clk,
    input logic         reset,
    input logic         clear,
    input logic         inc,
    input logic         dec,
    input logic [W-1:0] count
);

    underflow_a: assert property (@(posedge clk) disable iff (reset || clear)
        (dec && !inc) |-> (count != {W{1'b0}}));

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: blocks issue on RAW and capacity hazards, tracks
// in-flight instructions and counts stalled issue cycles.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int STALL_W      = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    input  logic [4:0]                        issue_rs1,
    input  logic [4:0]                        issue_rs2,
    input  logic                              issue_uses_rs1,
    input  logic                              issue_uses_rs2,
    input  logic [4:0]                        issue_rd,
    input  logic                              issue_writes_rd,
    output logic                              issue_ready,
    input  logic                              wb_valid,
    input  logic                              wb_writes_rd,
    input  logic [4:0]                        wb_rd,
    input  logic                              flush,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
    output logic                              busy,
    output logic [STALL_W-1:0]                stall_cycles
);

    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IF_W-1:0]    IF_ZERO    = {IF_W{1'b0}};
    localparam logic [IF_W-1:0]    IF_ONE     = {{(IF_W-1){1'b0}}, 1'b1};
    localparam logic [IF_W-1:0]    IF_MAX     = IF_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0] STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_MAX  = {STALL_W{1'b1}};

    // A pending producer is harmless only if it is the single one retiring now.
    function automatic logic raw_hazard(input logic [CNT_W-1:0] cnt, input logic retiring);
        return (cnt > CNT_ONE) || ((cnt == CNT_ONE) && !retiring);
    endfunction

    logic [CNT_W-1:0]   pend_s [NUM_REGS];
    logic               full_s [NUM_REGS];
    logic               wb_retire_s;
    logic               issue_fire_s;
    logic               raw_rs1_s;
    logic               raw_rs2_s;
    logic               rd_full_s;
    logic               inflight_full_s;
    logic [IF_W-1:0]    inflight_r;
    logic [IF_W-1:0]    inflight_nxt_s;
    logic [STALL_W-1:0] stall_r;

    assign pend_s[0]   = {CNT_W{1'b0}};
    assign full_s[0]   = 1'b0;
    assign wb_retire_s = wb_valid && wb_writes_rd;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
        pending_counter_m #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .inc   (issue_fire_s && issue_writes_rd && (issue_rd == reg_index_t'(i))),
            .dec   (wb_retire_s && (wb_rd == reg_index_t'(i))),
            .count (pend_s[i]),
            .full  (full_s[i])
        );
    end

    // Hazard detection; a same-cycle retirement of rd frees a slot in its counter.
    always_comb begin
        raw_rs1_s       = 1'b0;
        raw_rs2_s       = 1'b0;
        rd_full_s       = 1'b0;
        inflight_full_s = 1'b0;
        if (issue_uses_rs1 && is_tracked(issue_rs1)) begin
            raw_rs1_s = raw_hazard(pend_s[issue_rs1], wb_retire_s && (wb_rd == issue_rs1));
        end else begin
            raw_rs1_s = 1'b0;
        end
        if (issue_uses_rs2 && is_tracked(issue_rs2)) begin
            raw_rs2_s = raw_hazard(pend_s[issue_rs2], wb_retire_s && (wb_rd == issue_rs2));
        end else begin
            raw_rs2_s = 1'b0;
        end
        if (issue_writes_rd && is_tracked(issue_rd)) begin
            rd_full_s = full_s[issue_rd] && !(wb_retire_s && (wb_rd == issue_rd));
        end else begin
            rd_full_s = 1'b0;
        end
        inflight_full_s = (inflight_r == IF_MAX) && !wb_valid;
    end

    assign issue_ready  = !flush && !reset &&
                          !(raw_rs1_s || raw_rs2_s || rd_full_s || inflight_full_s);
    assign issue_fire_s = issue_valid && issue_ready;

    // In-flight next value; issue and retire in one cycle cancel.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({issue_fire_s, wb_valid})
            2'b10: begin
                if (inflight_r != IF_MAX) begin
                    inflight_nxt_s = inflight_r + IF_ONE;
                end else begin
                    inflight_nxt_s = inflight_r;
                end
            end
            2'b01: begin
                if (inflight_r != IF_ZERO) begin
                    inflight_nxt_s = inflight_r - IF_ONE;
                end else begin
                    inflight_nxt_s = inflight_r;
                end
            end
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // In-flight register; flush squashes everything outstanding.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            inflight_r <= IF_ZERO;
        end else begin
            inflight_r <= inflight_nxt_s;
        end
    end

    // Saturating stall counter; flush-forced stalls count too.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_r <= STALL_ZERO;
        end else if (issue_valid && !issue_ready && (stall_r != STALL_MAX)) begin
            stall_r <= stall_r + STALL_ONE;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign inflight_count = inflight_r;
    assign busy           = (inflight_r != IF_ZERO);
    assign stall_cycles   = stall_r;

    regfile_scoreboard_checker #(.W(IF_W)) u_inflight_chk (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (issue_fire_s),
        .dec   (wb_valid),
        .count (inflight_r)
    );

endmodule
